// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the handshaked data memory
//
// Holds the FSM state encoding, the latency-counter width and the byte-lane
// count helper used by data_memory_hs and dmem_array.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  // Counter only needs to reach READ_LAT-2, and READ_LAT tops out at 4.
  localparam int CNT_W = 2;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with per-byte write enables and optional lane parity
//
// Ports:
//   i_clk      rising-edge clock
//   i_wr_en    write strobe (already range-checked by the caller)
//   i_idx      word index
//   i_wdata    write data
//   i_be       per-byte write enable, bit i covers bits 8i+7:8i
//   i_par_inj  (DMEM_PARITY_EN only) invert stored parity of written lanes
//   o_rdata    asynchronous read of the indexed word
//   o_par_err  parity mismatch on the indexed word (0 without DMEM_PARITY_EN)
// Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_wr_en,
  input  logic [IDX_W-1:0]              i_idx,
  input  logic [DATA_W-1:0]             i_wdata,
  input  logic [lane_count(DATA_W)-1:0] i_be,
`ifdef DMEM_PARITY_EN
  input  logic                          i_par_inj,
`endif
  output logic [DATA_W-1:0]             o_rdata,
  output logic                          o_par_err
);

  localparam int LANES = lane_count(DATA_W);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

`ifdef DMEM_PARITY_EN
  logic [LANES-1:0] r_par [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (i_be[i]) r_par[i_idx][i] <= (^i_wdata[8*i +: 8]) ^ i_par_inj;
      end
    end
  end

  always_comb begin
    o_par_err = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if ((^o_rdata[8*i +: 8]) != r_par[i_idx][i]) o_par_err = 1'b1;
    end
  end
`else
  assign o_par_err = 1'b0;
`endif

endmodule

// File: rtl/data_memory_hs.sv
// rtl/data_memory_hs.sv - handshaked word-addressed data memory with configurable read latency
//
// Ports:
//   Clock, Reset_n (async, active low)
//   Req, MemWrite, MemRead, Adresa, WriteData, ByteEn   request channel
//   ParityInj (DMEM_PARITY_EN only)                     corrupt stored parity on write
//   Ready      request is accepted on an edge where Req && Ready
//   RespValid  one-cycle pulse, ReadData/AddrErr/ParityErr valid
//   ReadData   read result, held between responses
//   AddrErr    out-of-range flag (write: pulse after accept; read: with RespValid)
//   ParityErr  lane parity mismatch with RespValid (always 0 without DMEM_PARITY_EN)
// Optional feature macro: DMEM_PARITY_EN.
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic                          Req,
  input  logic                          MemWrite,
  input  logic                          MemRead,
  input  logic [ADDR_W-1:0]             Adresa,
  input  logic [DATA_W-1:0]             WriteData,
  input  logic [lane_count(DATA_W)-1:0] ByteEn,
`ifdef DMEM_PARITY_EN
  input  logic                          ParityInj,
`endif
  output logic                          Ready,
  output logic                          RespValid,
  output logic [DATA_W-1:0]             ReadData,
  output logic                          AddrErr,
  output logic                          ParityErr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT  = (READ_LAT > 1) ? CNT_W'(READ_LAT - 2) : '0;

  dmem_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ready;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_read_data;
  logic              r_addr_err;
  logic              r_par_err;
  // Snapshot taken at acceptance so the response is the pre-request word.
  logic [DATA_W-1:0] r_snap_data;
  logic              r_snap_oor;
  logic              r_snap_perr;

  logic              w_accept;
  logic              w_wr;
  logic              w_rd;
  logic              w_oor;
  logic [DATA_W-1:0] w_arr_rdata;
  logic              w_arr_perr;
  logic [DATA_W-1:0] w_word;
  logic              w_perr;

  assign w_accept = Req & r_ready;
  assign w_wr     = w_accept & MemWrite;
  assign w_rd     = w_accept & MemRead & ~MemWrite;  // write wins when both set
  assign w_oor    = ({1'b0, Adresa} >= DEPTH_EXT);
  assign w_word   = w_oor ? '0 : w_arr_rdata;
  assign w_perr   = ~w_oor & w_arr_perr;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .i_clk     (Clock),
    .i_wr_en   (w_wr & ~w_oor),
    .i_idx     (Adresa[IDX_W-1:0]),
    .i_wdata   (WriteData),
    .i_be      (ByteEn),
`ifdef DMEM_PARITY_EN
    .i_par_inj (ParityInj),
`endif
    .o_rdata   (w_arr_rdata),
    .o_par_err (w_arr_perr)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_read_data  <= '0;
      r_addr_err   <= 1'b0;
      r_par_err    <= 1'b0;
      r_snap_data  <= '0;
      r_snap_oor   <= 1'b0;
      r_snap_perr  <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_addr_err   <= 1'b0;
      r_par_err    <= 1'b0;
      case (r_state)
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state      <= ST_RESP;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b1;
            r_read_data  <= r_snap_data;
            r_addr_err   <= r_snap_oor;
            r_par_err    <= r_snap_perr;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          // IDLE and RESP both accept new requests.
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          if (w_wr && w_oor) r_addr_err <= 1'b1;
          if (w_rd) begin
            if (READ_LAT == 1) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_read_data  <= w_word;
              r_addr_err   <= w_oor;
              r_par_err    <= w_perr;
            end else begin
              r_state     <= ST_WAIT;
              r_ready     <= 1'b0;
              r_cnt       <= CNT_INIT;
              r_snap_data <= w_word;
              r_snap_oor  <= w_oor;
              r_snap_perr <= w_perr;
            end
          end
        end
      endcase
    end
  end

  assign Ready     = r_ready;
  assign RespValid = r_resp_valid;
  assign ReadData  = r_read_data;
  assign AddrErr   = r_addr_err;
  assign ParityErr = r_par_err;

endmodule
